// File: rtl/bm_pack_if.sv
// Buffer-read and framed-transmit signals of bm_pack.
// The master side is the packer; the slave side is the bm buffer plus the transmit path.
interface bm_pack_if;
    logic       bm_req;
    logic [7:0] bm_q;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_eop;

    modport master (output bm_req, input bm_q, output tx_data, output tx_vld, output tx_eop);
    modport slave  (input bm_req, output bm_q, input tx_data, input tx_vld, input tx_eop);
endinterface

// File: rtl/bm_pack.sv
// bm_pack: on each trigger, pulls PAY_LEN bytes from the bm buffer and frames them as
// sync / sequence / length / payload / checksum on a push-only byte stream.
module bm_pack #(
    parameter int unsigned PAY_LEN = 16,
    parameter int unsigned RD_LAT  = 2,
    parameter logic [7:0]  SYNC0   = 8'hEB,
    parameter logic [7:0]  SYNC1   = 8'h90
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pack_trig,
    bm_pack_if.master   bus,
    output logic        busy,
    output logic [15:0] seq_num,
    output logic [7:0]  drop_cnt
);
    typedef enum logic [2:0] {IDLE, SYNC_A, SYNC_B, SEQ_H, SEQ_L, LEN, PAY, CHK} state_e;

    localparam logic [7:0] LEN_B = 8'(PAY_LEN);

    state_e            state_q, state_d;
    logic [RD_LAT-1:0] req_pipe_q, req_pipe_d;
    logic [7:0]        req_cnt_q, req_cnt_d;
    logic [7:0]        pay_cnt_q, pay_cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_vld_q, tx_vld_d;
    logic              tx_eop_q, tx_eop_d;
    logic              busy_q, busy_d;
    logic [15:0]       seq_num_q, seq_num_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              req_now;
    logic              cap_vld;

    // Stage 0 of the request pipe is bm_req itself; the last stage marks the cycle bm_q is valid.
    assign cap_vld = req_pipe_q[RD_LAT-1];

    // NOTE: every variable is given a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        pay_cnt_d  = pay_cnt_q;
        sum_d      = sum_q;
        tx_data_d  = tx_data_q;
        tx_vld_d   = 1'b0;
        tx_eop_d   = 1'b0;
        busy_d     = (state_q != IDLE);
        seq_num_d  = seq_num_q;
        drop_cnt_d = drop_cnt_q;
        req_now    = 1'b0;

        if (pack_trig && (state_q != IDLE) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (pack_trig) begin
                    state_d   = SYNC_A;
                    req_cnt_d = 8'd0;
                    pay_cnt_d = 8'd0;
                    sum_d     = 8'd0;
                end
            end
            SYNC_A: begin
                tx_data_d = SYNC0;
                tx_vld_d  = 1'b1;
                state_d   = SYNC_B;
            end
            SYNC_B: begin
                tx_data_d = SYNC1;
                tx_vld_d  = 1'b1;
                state_d   = SEQ_H;
            end
            SEQ_H: begin
                tx_data_d = seq_num_q[15:8];
                tx_vld_d  = 1'b1;
                sum_d     = sum_q + seq_num_q[15:8];
                state_d   = SEQ_L;
            end
            SEQ_L: begin
                tx_data_d = seq_num_q[7:0];
                tx_vld_d  = 1'b1;
                sum_d     = sum_q + seq_num_q[7:0];
                state_d   = LEN;
            end
            LEN: begin
                tx_data_d = LEN_B;
                tx_vld_d  = 1'b1;
                sum_d     = sum_q + LEN_B;
                state_d   = PAY;
            end
            PAY: begin
                // Requests stop after PAY_LEN cycles even though captures are still in flight.
                if (req_cnt_q != LEN_B) begin
                    req_now   = 1'b1;
                    req_cnt_d = req_cnt_q + 8'd1;
                end
                if (cap_vld) begin
                    tx_data_d = bus.bm_q;
                    tx_vld_d  = 1'b1;
                    sum_d     = sum_q + bus.bm_q;
                    pay_cnt_d = pay_cnt_q + 8'd1;
                    if (pay_cnt_q == LEN_B - 8'd1) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                tx_data_d = 8'h00 - sum_q;
                tx_vld_d  = 1'b1;
                tx_eop_d  = 1'b1;
                seq_num_d = seq_num_q + 16'd1;
                state_d   = IDLE;
            end
        endcase

        req_pipe_d = (req_pipe_q << 1) | RD_LAT'(req_now);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_pipe_q <= '0;
            req_cnt_q  <= 8'd0;
            pay_cnt_q  <= 8'd0;
            sum_q      <= 8'd0;
            tx_data_q  <= 8'd0;
            tx_vld_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            busy_q     <= 1'b0;
            seq_num_q  <= 16'd0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            req_pipe_q <= req_pipe_d;
            req_cnt_q  <= req_cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            sum_q      <= sum_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            tx_eop_q   <= tx_eop_d;
            busy_q     <= busy_d;
            seq_num_q  <= seq_num_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.bm_req  = req_pipe_q[0];
    assign bus.tx_data = tx_data_q;
    assign bus.tx_vld  = tx_vld_q;
    assign bus.tx_eop  = tx_eop_q;
    assign busy        = busy_q;
    assign seq_num     = seq_num_q;
    assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_bm_pack.sv
// Self-checking bench for bm_pack: five parameter sets, a bm buffer model per instance,
// and a frame-level reference built from the frame layout and checksum rule.
module tb_bm_pack;
    localparam int N = 5;
    // Instance k uses PLV[k] / RLV[k]: (16,2) (1,1) (1,4) (255,1) (255,4).
    localparam logic [N-1:0][7:0] PLV = {8'd255, 8'd255, 8'd1, 8'd1, 8'd16};
    localparam logic [N-1:0][7:0] RLV = {8'd4, 8'd1, 8'd4, 8'd1, 8'd2};

    typedef struct packed {
        logic [31:0] rel;
        logic [7:0]  d;
        logic        eop;
    } rx_t;

    logic               clk_sys = 1'b0;
    logic               rst_n;
    logic [N-1:0]       trig;
    logic [N-1:0]       busy, req_w, vld_w, eop_w;
    logic [N-1:0][7:0]  txd_w, drop_w;
    logic [N-1:0][15:0] seq_w;
    logic               cnt_mode;
    int                 cyc = 0;
    int                 t0 [N];
    int                 seq_exp [N];
    int                 drop_exp [N];
    rx_t                rx_q [N][$];
    int                 req_q [N][$];
    logic [7:0]         iss_q [N][$];
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    for (genvar gi = 0; gi < N; gi++) begin : g
        localparam int PL = int'(PLV[gi]);
        localparam int RL = int'(RLV[gi]);
        bm_pack_if bif ();
        logic [3:0] hist = 4'd0;

        bm_pack #(.PAY_LEN(PL), .RD_LAT(RL)) u_dut (
            .clk_sys  (clk_sys),
            .rst_n    (rst_n),
            .pack_trig(trig[gi]),
            .bus      (bif.master),
            .busy     (busy[gi]),
            .seq_num  (seq_w[gi]),
            .drop_cnt (drop_w[gi])
        );

        assign req_w[gi] = bif.bm_req;
        assign vld_w[gi] = bif.tx_vld;
        assign eop_w[gi] = bif.tx_eop;
        assign txd_w[gi] = bif.tx_data;

        // Buffer model: the byte for a request cycle sits on bm_q RD_LAT-1 cycles later,
        // so it is sampled RD_LAT edges after bm_req rose; other cycles carry noise.
        always @(negedge clk_sys or negedge rst_n) begin : bm_model
            logic [7:0] b;
            if (!rst_n) begin
                hist     = 4'd0;
                bif.bm_q = 8'h00;
            end else begin
                hist = {hist[2:0], bif.bm_req};
                if (hist[RL-1]) begin
                    b = cnt_mode ? 8'(iss_q[gi].size() + 1) : 8'($urandom);
                    iss_q[gi].push_back(b);
                    bif.bm_q = b;
                end else begin
                    bif.bm_q = 8'($urandom);
                end
            end
        end

        always @(negedge clk_sys) begin : mon
            rx_t e;
            if (bif.tx_vld) begin
                e.rel = 32'(cyc - t0[gi]);
                e.d   = bif.tx_data;
                e.eop = bif.tx_eop;
                rx_q[gi].push_back(e);
            end
            if (bif.bm_req) req_q[gi].push_back(cyc - t0[gi]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on instance i starting at the current negedge. mode 0: plain,
    // 1: extra triggers at cycles 3/10/20, 2: trigger held for the whole busy window.
    task automatic do_frame(input int i, input int mode);
        int         pl, rl, n, rel, sum;
        logic [7:0] exp_b [$];
        pl = int'(PLV[i]);
        rl = int'(RLV[i]);
        rx_q[i].delete();
        req_q[i].delete();
        iss_q[i].delete();
        t0[i]   = cyc + 1;
        trig[i] = 1'b1;
        @(negedge clk_sys);
        trig[i] = 1'b0;
        n = 0;
        rel = 0;
        do begin
            @(negedge clk_sys);
            n++;
            rel = cyc - t0[i];
            trig[i] = (mode == 1 && (rel == 3 || rel == 10 || rel == 20)) ||
                      (mode == 2 && rel >= 1 && rel <= 5 + rl + pl);
            if (trig[i]) drop_exp[i] = (drop_exp[i] >= 255) ? 255 : drop_exp[i] + 1;
        end while ((busy[i] || rel < 2) && n < 600);
        trig[i] = 1'b0;
        check("frame_done", 32'(n < 600), 32'd1);
        check("busy_fall", 32'(rel), 32'(7 + rl + pl));

        exp_b.push_back(8'hEB);
        exp_b.push_back(8'h90);
        exp_b.push_back(8'(seq_exp[i] >> 8));
        exp_b.push_back(8'(seq_exp[i]));
        exp_b.push_back(8'(pl));
        for (int k = 0; k < iss_q[i].size(); k++) exp_b.push_back(iss_q[i][k]);
        sum = 0;
        for (int k = 2; k < exp_b.size(); k++) sum += int'(exp_b[k]);
        exp_b.push_back(8'(256 - (sum % 256)));

        check("issued", 32'(iss_q[i].size()), 32'(pl));
        check("req_cnt", 32'(req_q[i].size()), 32'(pl));
        for (int k = 0; k < req_q[i].size(); k++) check("req_cyc", 32'(req_q[i][k]), 32'(6 + k));
        check("byte_cnt", 32'(rx_q[i].size()), 32'(pl + 6));
        sum = 0;
        for (int k = 0; k < rx_q[i].size() && k < pl + 6; k++) begin
            check("byte", 32'(rx_q[i][k].d), 32'(exp_b[k]));
            check("byte_cyc", rx_q[i][k].rel, 32'((k < 5) ? k + 1 : k + 1 + rl));
            check("eop", 32'(rx_q[i][k].eop), 32'(k == pl + 5));
            if (k >= 2) sum += int'(rx_q[i][k].d);
        end
        check("zero_sum", 32'(sum % 256), 32'd0);
        seq_exp[i] = (seq_exp[i] + 1) % 65536;
        check("seq_next", 32'(seq_w[i]), 32'(seq_exp[i]));
        check("drops", 32'(drop_w[i]), 32'(drop_exp[i]));
    endtask

    initial begin
        int eops;
        trig     = '0;
        cnt_mode = 1'b1;
        rst_n    = 1'b0;
        for (int k = 0; k < N; k++) begin
            t0[k]       = 0;
            seq_exp[k]  = 0;
            drop_exp[k] = 0;
        end
        repeat (4) @(negedge clk_sys);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(req_w), 32'd0);
        check("rst_vld", 32'(vld_w), 32'd0);
        check("rst_eop", 32'(eop_w), 32'd0);
        check("rst_data", 32'(txd_w[0]), 32'd0);
        check("rst_seq", 32'(seq_w[0]), 32'd0);
        check("rst_drop", 32'(drop_w[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        // Counting payload 01..10: checksum is 0x68.
        do_frame(0, 0);
        check("t1_pay_first", 32'(rx_q[0][5].d), 32'h01);
        check("t1_pay_last", 32'(rx_q[0][20].d), 32'h10);
        check("t1_chk", 32'(rx_q[0][21].d), 32'h68);

        // Back-to-back: trigger in the first cycle with busy low.
        do_frame(0, 0);
        check("t2_seq_l", 32'(rx_q[0][3].d), 32'h01);

        // Sequence wrap FFFF -> 0000 on the PAY_LEN=1 instance.
        cnt_mode = 1'b0;
        force g[1].u_dut.seq_num_d = 16'hFFFF;
        @(negedge clk_sys);
        release g[1].u_dut.seq_num_d;
        seq_exp[1] = 16'hFFFF;
        check("seq_preload", 32'(seq_w[1]), 32'hFFFF);
        do_frame(1, 0);

        // Triggers while busy are dropped and counted; saturation at FF.
        do_frame(0, 1);
        check("t3_drop", 32'(drop_w[0]), 32'd3);
        do_frame(3, 2);
        do_frame(3, 2);
        check("t3_drop_sat", 32'(drop_w[3]), 32'hFF);

        // Reset asserted while payload byte 5 is on the output.
        rx_q[0].delete();
        t0[0]   = cyc + 1;
        trig[0] = 1'b1;
        @(negedge clk_sys);
        trig[0] = 1'b0;
        repeat (12) @(negedge clk_sys);
        check("t4_pre_req", 32'(req_w[0]), 32'd1);
        check("t4_pre_vld", 32'(vld_w[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_req", 32'(req_w[0]), 32'd0);
        check("t4_rst_vld", 32'(vld_w[0]), 32'd0);
        check("t4_rst_busy", 32'(busy[0]), 32'd0);
        check("t4_rst_seq", 32'(seq_w[0]), 32'd0);
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            seq_exp[k]  = 0;
            drop_exp[k] = 0;
        end
        repeat (2) @(negedge clk_sys);
        eops = 0;
        for (int k = 0; k < rx_q[0].size(); k++) eops += int'(rx_q[0][k].eop);
        check("t4_no_eop", 32'(eops), 32'd0);
        do_frame(0, 0);

        // Parameter sweep with random buffer contents.
        for (int i = 1; i < N; i++) begin
            do_frame(i, 0);
            do_frame(i, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
